// File: rtl/mul_issue_pkg.sv
// Shared definitions for the HI/LO multiply/divide issue controller:
// op-codes, unit select encodings, FSM states and the operand bundle.
package mul_issue_pkg;

  localparam logic [2:0] MUL_OP_MULTU = 3'd0;
  localparam logic [2:0] MUL_OP_DIVU  = 3'd1;
  localparam logic [2:0] MUL_OP_MFHI  = 3'd2;
  localparam logic [2:0] MUL_OP_MFLO  = 3'd3;
  localparam logic [2:0] MUL_OP_MTHI  = 3'd4;
  localparam logic [2:0] MUL_OP_MTLO  = 3'd5;

  localparam logic MUL_MUL      = 1'b0;
  localparam logic MUL_DIV      = 1'b1;
  localparam logic MUL_SEL_HIGH = 1'b1;
  localparam logic MUL_SEL_LOW  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] db;
  } mul_opnd_t;

endpackage

// File: rtl/mul_timeout.sv
// Busy-phase watchdog: counts enabled cycles, flags expiry at TIMEOUT-1.
// Zero latency on expired; no backpressure.
module mul_timeout #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mul_issue.sv
// Issue controller for the HI/LO mul/div unit: unit controls in the accept cycle, MFHI/MFLO data 1 cycle later.
// Backpressure: Stall holds the execute stage while a MULTU/DIVU is outstanding.
module mul_issue
  import mul_issue_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Op_Valid,
  input  logic [2:0]  Op_Code,
  input  logic [31:0] Op_Rs,
  input  logic [31:0] Op_Rt,
  output logic        Stall,
  output logic        Rd_Valid,
  output logic [31:0] Rd_Data,
  output logic        Err,
  output logic        MUL_Start,
  output logic        MUL_SelMD,
  output logic        MUL_SelHL,
  output logic        MUL_Write,
  output logic [31:0] MUL_DA,
  output logic [31:0] MUL_DB,
  input  logic        MUL_Flag,
  input  logic [31:0] MUL_DC
);

  state_t    state_q, state_d;
  mul_opnd_t opnd_q;
  logic      sel_hl_q;
  logic      err_q;
  logic      rd_valid_q;
  logic [31:0] rd_data_q;

  logic op_md, op_mf, op_mt, op_req;
  logic acc_md, acc_mf, acc_mt;
  logic sel_now;
  logic cnt_clr, cnt_en, expired, err_set;

  assign op_md = (Op_Code == MUL_OP_MULTU) || (Op_Code == MUL_OP_DIVU);
  assign op_mf = (Op_Code == MUL_OP_MFHI)  || (Op_Code == MUL_OP_MFLO);
  assign op_mt = (Op_Code == MUL_OP_MTHI)  || (Op_Code == MUL_OP_MTLO);

  // Codes 6-7 never request, so they neither stall nor act.
  assign op_req = Op_Valid && (op_md || op_mf || op_mt) && !Reset;

  assign Stall  = op_req && (state_q != ST_IDLE);
  assign acc_md = op_req && (state_q == ST_IDLE) && op_md;
  assign acc_mf = op_req && (state_q == ST_IDLE) && op_mf;
  assign acc_mt = op_req && (state_q == ST_IDLE) && op_mt;

  assign sel_now = ((Op_Code == MUL_OP_MFHI) || (Op_Code == MUL_OP_MTHI)) ? MUL_SEL_HIGH : MUL_SEL_LOW;

  mul_timeout #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flag is only examined from BUSY on, so a stale Flag during Start is harmless.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_md) begin
          state_d = ST_BUSY;
          cnt_clr = 1'b1;
        end
      end
      ST_BUSY: begin
        if (MUL_Flag) begin
          state_d = ST_SETTLE;
        end else if (expired) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      opnd_q     <= '0;
      sel_hl_q   <= MUL_SEL_LOW;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (acc_md) begin
        opnd_q <= '{da: Op_Rs, db: Op_Rt};
      end else if (acc_mt) begin
        opnd_q.da <= Op_Rs;
      end
      if (acc_mf || acc_mt) begin
        sel_hl_q <= sel_now;
      end
      if (acc_md) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
      rd_valid_q <= acc_mf;
      if (acc_mf) begin
        rd_data_q <= MUL_DC;
      end
    end
  end

  // Operands and select go out combinationally in the accept cycle, then hold.
  assign MUL_Start = acc_md;
  assign MUL_SelMD = acc_md && ((Op_Code == MUL_OP_DIVU) ? MUL_DIV : MUL_MUL);
  assign MUL_Write = acc_mt;
  assign MUL_SelHL = (acc_mf || acc_mt) ? sel_now : sel_hl_q;
  assign MUL_DA    = (acc_md || acc_mt) ? Op_Rs : opnd_q.da;
  assign MUL_DB    = acc_md ? Op_Rt : opnd_q.db;

  assign Err      = err_q;
  assign Rd_Valid = rd_valid_q;
  assign Rd_Data  = rd_data_q;

endmodule

// File: tb/tb_mul_issue.sv
// Bench for mul_issue: behavioural HI/LO unit plus a cycle-budget reference model
// (free_at / err_at timestamps) checked every cycle with immediate assertions.
module tb_mul_issue;

  localparam int T  = 16;
  localparam int CW = 5;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Op_Valid = 1'b0;
  logic [2:0]  Op_Code = 3'd0;
  logic [31:0] Op_Rs = 32'd0;
  logic [31:0] Op_Rt = 32'd0;
  logic        Stall, Rd_Valid, Err;
  logic [31:0] Rd_Data;
  logic        MUL_Start, MUL_SelMD, MUL_SelHL, MUL_Write;
  logic [31:0] MUL_DA, MUL_DB;
  logic        u_flag;
  logic [31:0] u_dc;

  mul_issue #(.TIMEOUT(T), .CW(CW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Op_Valid  (Op_Valid),
    .Op_Code   (Op_Code),
    .Op_Rs     (Op_Rs),
    .Op_Rt     (Op_Rt),
    .Stall     (Stall),
    .Rd_Valid  (Rd_Valid),
    .Rd_Data   (Rd_Data),
    .Err       (Err),
    .MUL_Start (MUL_Start),
    .MUL_SelMD (MUL_SelMD),
    .MUL_SelHL (MUL_SelHL),
    .MUL_Write (MUL_Write),
    .MUL_DA    (MUL_DA),
    .MUL_DB    (MUL_DB),
    .MUL_Flag  (u_flag),
    .MUL_DC    (u_dc)
  );

  always #5 Clk = ~Clk;

  // Behavioural HI/LO unit: result and Flag appear u_lat edges after Start.
  int          u_lat = 0;
  bit          u_force_low = 1'b0;
  int          u_cd;
  logic [31:0] u_hi, u_lo;
  logic [63:0] u_res;

  function automatic logic [63:0] unit_calc(input logic md, input logic [31:0] a, input logic [31:0] b);
    if (!md) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  assign u_dc = u_flag ? (MUL_SelHL ? u_hi : u_lo) : 32'd0;

  always @(posedge Clk) begin
    if (Reset) begin
      u_flag <= 1'b0; u_hi <= '0; u_lo <= '0; u_cd <= 0; u_res <= '0;
    end else if (MUL_Start) begin
      u_res <= unit_calc(MUL_SelMD, MUL_DA, MUL_DB);
      if (u_force_low) begin
        u_flag <= 1'b0; u_cd <= 0;
      end else if (u_lat == 0) begin
        u_flag <= 1'b1; u_cd <= 0;
        {u_hi, u_lo} <= unit_calc(MUL_SelMD, MUL_DA, MUL_DB);
      end else begin
        u_flag <= 1'b0; u_cd <= u_lat;
      end
    end else if (MUL_Write) begin
      if (MUL_SelHL) u_hi <= MUL_DA; else u_lo <= MUL_DA;
      u_flag <= 1'b1;
    end else if (u_cd != 0) begin
      u_cd <= u_cd - 1;
      if (u_cd == 1) begin
        u_flag <= 1'b1; {u_hi, u_lo} <= u_res;
      end
    end
  end

  // Reference model state
  int          n_checks = 0, n_pass = 0, n_fail = 0;
  int          cyc = 0, free_at = 0, err_at = -1;
  logic        err_exp = 1'b0, sel_exp = 1'b0, rdv_exp = 1'b0, exp_valid = 1'b0;
  logic [31:0] da_exp = '0, db_exp = '0, rd_exp = '0, exp_hi = '0, exp_lo = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt,
                      input int lat, input bit fl, output bit acc, output bit stl);
    bit   known, md, mf, mt;
    logic sel_now;
    Op_Valid = v; Op_Code = code; Op_Rs = rs; Op_Rt = rt;
    u_lat = lat; u_force_low = fl;
    known = (code <= 3'd5);
    md = (code <= 3'd1);
    mf = (code == 3'd2) || (code == 3'd3);
    mt = (code == 3'd4) || (code == 3'd5);
    stl = v && known && (cyc < free_at);
    acc = v && known && !stl;
    sel_now = sel_exp;
    if (acc && (mf || mt)) sel_now = (code == 3'd2) || (code == 3'd4);
    @(negedge Clk);
    chk("stall",   32'(Stall),     32'(stl));
    chk("start",   32'(MUL_Start), 32'(acc && md));
    chk("selmd",   32'(MUL_SelMD), 32'(acc && code == 3'd1));
    chk("write",   32'(MUL_Write), 32'(acc && mt));
    chk("selhl",   32'(MUL_SelHL), 32'(sel_now));
    chk("da",      MUL_DA, (acc && (md || mt)) ? rs : da_exp);
    chk("db",      MUL_DB, (acc && md) ? rt : db_exp);
    chk("rd_vld",  32'(Rd_Valid),  32'(rdv_exp));
    chk("rd_data", Rd_Data, rd_exp);
    chk("err",     32'(Err),       32'(err_exp));
    @(posedge Clk);
    if (cyc == err_at) err_exp = 1'b1;
    rdv_exp = acc && mf;
    if (acc && mf) rd_exp = exp_valid ? ((code == 3'd2) ? exp_hi : exp_lo) : 32'd0;
    sel_exp = sel_now;
    if (acc && (md || mt)) da_exp = rs;
    if (acc && md) begin
      db_exp  = rt;
      err_exp = 1'b0;
      if (fl) begin
        free_at = cyc + 1 + T; err_at = cyc + T; exp_valid = 1'b0;
      end else begin
        free_at = cyc + 3 + lat; err_at = -1; exp_valid = 1'b1;
        if (code == 3'd0) {exp_hi, exp_lo} = 64'(rs) * 64'(rt);
        else begin exp_lo = rs / rt; exp_hi = rs % rt; end
      end
    end
    if (acc && mt) begin
      if (code == 3'd4) exp_hi = rs; else exp_lo = rs;
      exp_valid = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt,
                       input int lat, input bit fl, output int stalls);
    bit acc, stl;
    acc = 1'b0; stalls = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      step(1'b1, code, rs, rt, lat, fl, acc, stl);
      if (stl) stalls++;
    end
    chk("issue_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    bit acc, stl;
    step(1'b0, 3'd0, 32'd0, 32'd0, 0, 1'b0, acc, stl);
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1; Op_Valid = 1'b0; u_force_low = 1'b0; u_lat = 0;
    repeat (n) @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc += n; free_at = cyc; err_at = -1;
    err_exp = 0; sel_exp = 0; rdv_exp = 0; exp_valid = 0;
    rd_exp = '0; da_exp = '0; db_exp = '0; exp_hi = '0; exp_lo = '0;
  endtask

  initial begin
    int          s;
    bit          acc, stl, hold, fl, v;
    logic [2:0]  c;
    logic [31:0] a, b;
    int          lat;

    do_reset(2);
    idle();

    // MULTU 6*7 then MFLO held until IDLE
    issue(3'd0, 32'd6, 32'd7, 2, 1'b0, s);
    issue(3'd3, 32'd0, 32'd0, 0, 1'b0, s);
    chk("mflo_stalls", 32'(s), 32'd4);
    chk("mflo_42", Rd_Data, 32'd42);
    idle();
    idle();
    chk("rd_vld_pulse", 32'(Rd_Valid), 32'd0);

    // DIVU 100/7
    issue(3'd1, 32'd100, 32'd7, 4, 1'b0, s);
    issue(3'd3, 32'd0, 32'd0, 0, 1'b0, s);
    chk("div_lo", Rd_Data, 32'd14);
    issue(3'd2, 32'd0, 32'd0, 0, 1'b0, s);
    chk("div_hi", Rd_Data, 32'd2);

    // MTHI then MFHI
    issue(3'd4, 32'hDEAD_BEEF, 32'd0, 0, 1'b0, s);
    issue(3'd2, 32'd0, 32'd0, 0, 1'b0, s);
    chk("mthi_mfhi", Rd_Data, 32'hDEAD_BEEF);

    // Timeout, then recovery where Flag and expiry coincide
    issue(3'd0, 32'd3, 32'd5, 0, 1'b1, s);
    issue(3'd3, 32'd0, 32'd0, 0, 1'b0, s);
    chk("timeout_stalls", 32'(s), 32'(T));
    chk("timeout_err", 32'(Err), 32'd1);
    issue(3'd0, 32'd2, 32'd3, T - 1, 1'b0, s);
    chk("err_cleared", 32'(Err), 32'd0);
    issue(3'd3, 32'd0, 32'd0, 0, 1'b0, s);
    chk("edge_stalls", 32'(s), 32'(T + 1));
    chk("edge_err", 32'(Err), 32'd0);
    chk("edge_data", Rd_Data, 32'd6);

    // Reset two cycles into BUSY
    issue(3'd0, 32'd11, 32'd13, 10, 1'b0, s);
    idle();
    idle();
    do_reset(1);
    issue(3'd3, 32'd0, 32'd0, 0, 1'b0, s);
    chk("post_reset_stalls", 32'(s), 32'd0);
    idle();

    // Stale Flag from MTLO during Start
    issue(3'd5, 32'h1234, 32'd0, 0, 1'b0, s);
    issue(3'd0, 32'd9, 32'd9, 3, 1'b0, s);
    issue(3'd3, 32'd0, 32'd0, 0, 1'b0, s);
    chk("stale_stalls", 32'(s), 32'd5);
    chk("stale_data", Rd_Data, 32'd81);

    // Back-to-back MULTU at minimum spacing; MFLO then MULTU overlap
    issue(3'd0, 32'd4, 32'd5, 0, 1'b0, s);
    issue(3'd0, 32'd7, 32'd8, 0, 1'b0, s);
    chk("b2b_stalls", 32'(s), 32'd2);
    issue(3'd3, 32'd0, 32'd0, 0, 1'b0, s);
    chk("b2b_data", Rd_Data, 32'd56);
    issue(3'd0, 32'd1, 32'd1, 0, 1'b0, s);
    chk("overlap_stalls", 32'(s), 32'd0);

    // Randomized traffic; a stalled op is held stable
    hold = 1'b0; v = 1'b0; c = 3'd0; a = '0; b = '0; lat = 0; fl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        v   = ($urandom_range(0, 9) < 7);
        c   = 3'($urandom_range(0, 7));
        a   = $urandom;
        b   = $urandom;
        if (c == 3'd1 && $urandom_range(0, 1) == 1) begin
          a = $urandom_range(0, 1000);
          b = $urandom_range(1, 50);
        end
        if (b == 32'd0) b = 32'd1;
        lat = $urandom_range(0, 5);
        fl  = ($urandom_range(0, 19) == 0);
      end
      step(v, c, a, b, lat, fl, acc, stl);
      hold = stl;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_issue.md
# mul_issue

Issue-side controller for the HI/LO multiply/divide unit. It sits between the execute stage and the unit. It turns decoded MULTU/DIVU/MFHI/MFLO/MTHI/MTLO operations into the unit's Start/SelMD/SelHL/Write handshake. It tracks the unit's completion flag, stalls the pipeline while a result is pending, and returns MFHI/MFLO data to the writeback path.

## Interface
- TIMEOUT, 64: maximum cycles in BUSY before the operation is abandoned; must be ≥ 2.
- CW, 7: width of the timeout counter; must satisfy 2^CW > TIMEOUT.
- Clk  in  1  clock; reset Reset, synchronous, active-high; clock Clk.
- Reset  in  1  synchronous active-high reset.
- Op_Valid  in  1  decoded mul-class operation present this cycle.
- Op_Code  in  3  0=MULTU, 1=DIVU, 2=MFHI, 3=MFLO, 4=MTHI, 5=MTLO; 6–7 are ignored (no action, no stall).
- Op_Rs, Op_Rt  in  32 each  operand values.
- Stall  out  1  hold the execute stage; combinational.
- Rd_Valid  out  1  one-cycle pulse; Rd_Data is valid.
- Rd_Data  out  32  MFHI/MFLO result.
- Err  out  1  sticky timeout flag; cleared by Reset or the next accepted MULTU/DIVU.
- MUL_Start, MUL_SelMD, MUL_SelHL, MUL_Write  out  1 each  unit controls.
- MUL_DA, MUL_DB  out  32 each  unit operands.
- MUL_Flag  in  1  unit completion flag.
- MUL_DC  in  32  unit read data; 0 while MUL_Flag=0.

## Operation
- States: IDLE, BUSY, SETTLE.
- Accept rule: an operation is accepted when Op_Valid=1, Op_Code ≤ 5 and state=IDLE. Otherwise Stall = Op_Valid && Op_Code≤5 && state≠IDLE.
- MULTU/DIVU accepted:
  - MUL_Start=1 for one cycle; MUL_SelMD = Op_Code[0]; MUL_DA=Op_Rs, MUL_DB=Op_Rt.
  - Operands are registered and held stable until the state returns to IDLE.
  - Next state BUSY; counter cleared; Err cleared.
- BUSY:
  - MUL_Flag=1 → SETTLE.
  - Otherwise the counter increments. When counter = TIMEOUT−1 with no Flag: Err←1, state → IDLE.
  - MUL_Flag is ignored in the Start cycle, because a stale Flag from the previous op may still be high.
- SETTLE: lasts exactly one cycle (the unit copies the result into HI/LO on this edge), then → IDLE.
- MFHI/MFLO accepted:
  - MUL_SelHL = (Op_Code==MFHI), driven the same cycle.
  - Rd_Data←MUL_DC at the edge; Rd_Valid=1 the following cycle.
- MTHI/MTLO accepted: MUL_Write=1 and MUL_SelHL = (Op_Code==MTHI) for one cycle; MUL_DA=Op_Rs.
- Default output values:
  - Start, Write and SelMD are 0 outside their accept cycle.
  - SelHL holds its last value.
  - MUL_DA/MUL_DB hold their last values.

## Timing
- Reset values: state IDLE, counter 0; Stall, Rd_Valid, Err, MUL_Start, MUL_Write, MUL_SelMD, MUL_SelHL all 0; Rd_Data, MUL_DA, MUL_DB all 0.
- Reset mid-BUSY: return to IDLE on the next edge. The unit is reset by the same Reset, so no Flag is pending afterwards.
- Stall is combinational from Op_Valid/Op_Code/state. The stage holds Op_* stable while Stall=1.
- Op-to-Stall latency:
  - MFLO issued the cycle after MULTU is accepted: Stall=1 through BUSY and SETTLE.
  - The operation is accepted the first IDLE cycle.
  - Rd_Valid follows one cycle after acceptance.
- Back-to-back MULTU: the second is accepted only in IDLE. Minimum spacing is Start + BUSY (≥1 cycle) + SETTLE = 3 cycles.
- Flag=1 and counter=TIMEOUT−1 in the same BUSY cycle: Flag wins (SETTLE, Err stays 0).
- Rd_Valid and MUL_Start may be high in the same cycle: MFLO accepted, then MULTU accepted the next cycle.
- Division by zero is forwarded unchanged; result values are the unit's responsibility.

## Structure
- Shared include header mul_defs:
  - op-code constants MUL_OP_MULTU..MUL_OP_MTLO;
  - existing MUL_MUL/MUL_DIV and MUL_SEL_HIGH/MUL_SEL_LOW defines;
  - state encodings.
- One sub-module, mul_timeout: CW-bit counter with clear, enable and an expiry output at TIMEOUT−1.
- Remainder is a single FSM plus output registers.

## Test plan
- MULTU Rs=6, Rt=7; then MFLO → Stall held until IDLE; Rd_Data=42; Rd_Valid pulse 1 cycle.
- DIVU 100/7; then MFLO, MFHI → Rd_Data 14, then 2.
- MTHI 0xDEADBEEF; next cycle MFHI → MUL_Write pulse with SelHL=1; Rd_Data=0xDEADBEEF once unit Flag is 1.
- Unit Flag forced 0 after MULTU → Err=1 exactly TIMEOUT cycles after Start; state IDLE; next MULTU clears Err.
- Reset asserted 2 cycles into BUSY → all outputs at reset values next cycle; MFLO accepted immediately after.
- Flag stale high during Start cycle → controller stays in BUSY until the fresh Flag; no early SETTLE.
